// File: rtl/writeback_pkg.sv
// Shared types and constants for the register writeback path.
// Optional feature macro used by register_writeback: WRITEBACK_BYPASS_EN.
// X_LENGTH and REGISTER_WIDTH normally come from defines.sv; the fallbacks
// below only apply when that file has not been read first.
`ifndef X_LENGTH
`define X_LENGTH 32
`endif
`ifndef REGISTER_WIDTH
`define REGISTER_WIDTH 5
`endif

package writeback_pkg;

  localparam int WB_XLEN  = `X_LENGTH;
  localparam int WB_IDX_W = `REGISTER_WIDTH;

  // Arbiter grant encoding; also the value held in last_grant.
  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  // One result beat: destination index plus value.
  typedef struct packed {
    logic [WB_IDX_W-1:0] rd;
    logic [WB_XLEN-1:0]  data;
  } wb_beat_t;

endpackage

// File: rtl/writeback_hold_slot.sv
// One-entry hold buffer for a result channel. Beats targeting x0 are
// accepted and dropped so they never reach the arbiter.
module writeback_hold_slot
  import writeback_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  wb_beat_t in_beat,
  output logic     in_ready,
  input  logic     grant,
  output logic     hold_valid,
  output wb_beat_t hold_beat
);

  logic     valid_reg;
  wb_beat_t beat_reg;
  logic     accept;
  logic     store;

  // A slot can take a new beat when empty or when it drains this cycle.
  assign in_ready   = rst_n && (!valid_reg || grant);
  assign accept     = in_valid && in_ready;
  assign store      = accept && (in_beat.rd != '0);
  assign hold_valid = valid_reg;
  assign hold_beat  = beat_reg;

  // Slot state: load on a stored beat, empty on grant, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      beat_reg  <= '0;
    end else if (store) begin
      valid_reg <= 1'b1;
      beat_reg  <= in_beat;
    end else if (grant) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Register file write-side driver: two buffered result channels (ALU, LSU),
// round-robin arbitration into one registered write port, and a pending
// scoreboard for RAW/WAW stalls at issue.
// Optional feature macro: WRITEBACK_BYPASS_EN (forwards the committing write
// to the source operand read ports).
module register_writeback
  import writeback_pkg::*;
#(
  parameter int XLEN = WB_XLEN,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  output logic                    issue_ready,
  input  logic [$clog2(NREG)-1:0] rs1_index,
  input  logic [$clog2(NREG)-1:0] rs2_index,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
`ifdef WRITEBACK_BYPASS_EN
  input  logic [XLEN-1:0]         rs1_rf_data,
  input  logic [XLEN-1:0]         rs2_rf_data,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
`endif
  input  logic                    alu_valid,
  input  logic [$clog2(NREG)-1:0] alu_rd,
  input  logic [XLEN-1:0]         alu_data,
  output logic                    alu_ready,
  input  logic                    lsu_valid,
  input  logic [$clog2(NREG)-1:0] lsu_rd,
  input  logic [XLEN-1:0]         lsu_data,
  output logic                    lsu_ready,
  output logic                    rd_write_enable,
  output logic [$clog2(NREG)-1:0] rd_write_index,
  output logic [XLEN-1:0]         rd_write_data
);

  localparam int IDX_W = $clog2(NREG);

  // Channel 0 is the ALU, channel 1 the LSU, matching the grant encoding.
  logic     [1:0] ch_valid;
  logic     [1:0] ch_ready;
  wb_beat_t       ch_beat    [2];
  logic     [1:0] slot_valid;
  wb_beat_t       slot_beat  [2];
  logic     [1:0] slot_grant;

  logic           last_grant_reg;
  logic           grant_valid;
  logic           grant_sel;
  wb_beat_t       granted_beat;

  logic             wr_en_reg;
  logic [IDX_W-1:0] wr_idx_reg;
  logic [XLEN-1:0]  wr_data_reg;

  logic [NREG-1:0]  pending_reg;
  logic [NREG-1:0]  pending_next;
  logic             issue_fire;

  assign ch_valid   = {lsu_valid, alu_valid};
  assign ch_beat[0] = '{rd: alu_rd, data: alu_data};
  assign ch_beat[1] = '{rd: lsu_rd, data: lsu_data};
  assign alu_ready  = ch_ready[0];
  assign lsu_ready  = ch_ready[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      writeback_hold_slot u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (ch_valid[gi]),
        .in_beat    (ch_beat[gi]),
        .in_ready   (ch_ready[gi]),
        .grant      (slot_grant[gi]),
        .hold_valid (slot_valid[gi]),
        .hold_beat  (slot_beat[gi])
      );
    end
  endgenerate

  // Round-robin pick: a lone valid slot wins; on contention the channel
  // that did not win last time goes first.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = last_grant_reg;
    case (slot_valid)
      2'b01: begin
        grant_valid = 1'b1;
        grant_sel   = GRANT_ALU;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_sel   = GRANT_LSU;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_sel   = ~last_grant_reg;
      end
      default: ;
    endcase
  end

  assign slot_grant[0] = grant_valid && (grant_sel == GRANT_ALU);
  assign slot_grant[1] = grant_valid && (grant_sel == GRANT_LSU);
  assign granted_beat  = (grant_sel == GRANT_LSU) ? slot_beat[1] : slot_beat[0];

  // Remember the last winner; unchanged on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_reg <= GRANT_ALU;
    end else if (grant_valid) begin
      last_grant_reg <= grant_sel;
    end
  end

  // Registered write port: index/data hold their value when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_reg   <= 1'b0;
      wr_idx_reg  <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= grant_valid;
      if (grant_valid) begin
        wr_idx_reg  <= granted_beat.rd;
        wr_data_reg <= granted_beat.data;
      end
    end
  end

  assign rd_write_enable = wr_en_reg;
  assign rd_write_index  = wr_idx_reg;
  assign rd_write_data   = wr_data_reg;

  // WAW hazards stall issue; x0 is never pending so it is always ready.
  assign issue_ready = rst_n && !pending_reg[issue_rd];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

  // Scoreboard update: clear on commit, then set on issue so a same-index
  // set overrides the clear.
  always_comb begin
    pending_next = pending_reg;
    if (wr_en_reg) begin
      pending_next[wr_idx_reg] = 1'b0;
    end
    if (issue_fire) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

`ifdef WRITEBACK_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = wr_en_reg && (wr_idx_reg == rs1_index) && (rs1_index != '0);
  assign rs2_hit = wr_en_reg && (wr_idx_reg == rs2_index) && (rs2_index != '0);

  // The committing value is visible this cycle, so the source is no longer
  // busy unless a new writer to that index issues at the same time.
  assign rs1_busy = pending_reg[rs1_index] &&
                    !(rs1_hit && !(issue_fire && (issue_rd == rs1_index)));
  assign rs2_busy = pending_reg[rs2_index] &&
                    !(rs2_hit && !(issue_fire && (issue_rd == rs2_index)));
  assign rs1_data = rs1_hit ? wr_data_reg : rs1_rf_data;
  assign rs2_data = rs2_hit ? wr_data_reg : rs2_rf_data;
`else
  assign rs1_busy = pending_reg[rs1_index];
  assign rs2_busy = pending_reg[rs2_index];
`endif

endmodule
